// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit counter must hold values 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             overflow;

   modport master (
      output start, a, b,
      input  ready, busy, done, diff, bout, overflow
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, diff, bout, overflow
   );
endinterface

// File: rtl/serial_subtractor_fsb.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Reports unsigned borrow and two's-complement overflow on completion.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_subtractor_if.slave    bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_s;
   logic             bnext_s;
   logic [WIDTH-1:0] res_shift_s;

   full_subtractor_bit u_fsb (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (d_s),
      .bout (bnext_s)
   );

   assign res_shift_s = {d_s, res_q[WIDTH-1:1]};

   // Next-state, datapath and output-register logic
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               res_d    = {WIDTH{1'b0}};
               borrow_d = 1'b0;
               cnt_d    = {CW{1'b0}};
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            res_d    = res_shift_s;
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            borrow_d = bnext_s;
            cnt_d    = cnt_q + CW'(1);
            // On the last step a_sh/b_sh bit 0 still holds the operand MSBs.
            if (cnt_q == LAST_CNT) begin
               diff_d  = res_shift_s;
               bout_d  = bnext_s;
               ovf_d   = (a_sh_q[0] != b_sh_q[0]) && (d_s != a_sh_q[0]);
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d == SHIFT);
      done_d  = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= {WIDTH{1'b0}};
         b_sh_q   <= {WIDTH{1'b0}};
         res_q    <= {WIDTH{1'b0}};
         borrow_q <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         diff_q   <= {WIDTH{1'b0}};
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.diff     = diff_q;
   assign bus.bout     = bout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic model.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {bout, overflow, diff} from plain integer arithmetic.
   function automatic logic [5:0] model(input int a, input int b);
      int d, sa, sb, sd;
      logic bo, ov;
      d  = (a - b) & 15;
      bo = (a < b);
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      sd = sa - sb;
      ov = (sd > 7) || (sd < -8);
      return {bo, ov, 4'(d)};
   endfunction

   task automatic run_op(input string tag, input int a, input int b);
      int cyc, busy_cnt, hold_bad, waitc;
      logic [3:0] prev_diff;
      waitc = 0;
      while (!bus.ready && waitc < 20) begin
         tick();
         waitc++;
      end
      check({tag, "_rdy"}, 32'(bus.ready), 32'd1);
      prev_diff = bus.diff;
      bus.a     = 4'(a);
      bus.b     = 4'(b);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a     = 4'($urandom);
      bus.b     = 4'($urandom);
      cyc = 1; busy_cnt = 0; hold_bad = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) busy_cnt++;
         if (bus.diff !== prev_diff) hold_bad++;
         tick();
         cyc++;
      end
      check({tag, "_done_cyc"}, 32'(cyc), 32'd5);
      check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd4);
      check({tag, "_hold"}, 32'(hold_bad), 32'd0);
      check({tag, "_res"}, {26'd0, bus.bout, bus.overflow, bus.diff}, {26'd0, model(a, b)});
      tick();
      check({tag, "_rdy_after"}, {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
   endtask

   initial begin
      int dones, cyc, accepts, last_acc, idle;
      logic [5:0] exp_q[$];
      logic [5:0] e;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = 4'd0;
      bus.b     = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
      check("reset_ctl", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
      check("reset_res", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'd0);

      run_op("d5m3", 5, 3);
      check("d5m3_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h02);
      run_op("d3m5", 3, 5);
      check("d3m5_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h2E);
      run_op("d0mF", 0, 15);
      check("d0mF_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h21);
      run_op("d8m1", 8, 1);
      check("d8m1_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h17);
      run_op("d7mF", 7, 15);
      check("d7mF_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h38);
      run_op("d9m9", 9, 9);
      check("d9m9_const", {26'd0, bus.bout, bus.overflow, bus.diff}, 32'h00);

      // Noise on start/a/b while busy must not disturb the accepted operation.
      bus.a = 4'hA; bus.b = 4'h3; bus.start = 1'b1;
      tick();
      dones = 0;
      for (int i = 1; i <= 10; i++) begin
         if (bus.done) begin
            dones++;
            check("noise_res", {26'd0, bus.bout, bus.overflow, bus.diff}, {26'd0, model(10, 3)});
         end
         bus.start = bus.busy;
         bus.a     = 4'($urandom);
         bus.b     = 4'($urandom);
         tick();
      end
      bus.start = 1'b0;
      check("noise_dones", 32'(dones), 32'd1);

      // Reset during SHIFT discards the operation.
      tick();
      bus.a = 4'd9; bus.b = 4'd4; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("rst_mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_mid_ctl", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
      check("rst_mid_diff", 32'(bus.diff), 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) dones++;
         tick();
      end
      check("rst_mid_nodone", 32'(dones), 32'd0);
      run_op("d6m2", 6, 2);

      // Continuous start: 1000 random ops, accept spacing WIDTH+2.
      accepts = 0; last_acc = -1; cyc = 0;
      bus.start = 1'b1;
      while ((accepts < 1000 || exp_q.size() != 0) && cyc < 7000) begin
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               check("stream_spurious_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("stream_res", {26'd0, bus.bout, bus.overflow, bus.diff}, {26'd0, e});
            end
         end
         bus.a = 4'($urandom);
         bus.b = 4'($urandom);
         if (accepts >= 1000) bus.start = 1'b0;
         if (bus.ready && bus.start) begin
            exp_q.push_back(model(int'(bus.a), int'(bus.b)));
            if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            accepts++;
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      check("stream_complete", 32'(accepts), 32'd1000);
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      idle = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) idle++;
         tick();
      end
      check("final_quiet", 32'(idle), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
